// File: rtl/proc_pkg.sv
// Shared definitions for the processor issue path: opcodes, widths,
// issue FSM state encoding and the packed instruction layout.
package proc_pkg;

  localparam int OPW  = 4;
  localparam int PSRW = 5;
  localparam int CCW  = 5;
  localparam int CNTW = 16;
  localparam int DATW = 32;

  localparam logic [OPW-1:0] NOP = 4'b0000;
  localparam logic [OPW-1:0] LD  = 4'b0001;
  localparam logic [OPW-1:0] STR = 4'b0010;
  localparam logic [OPW-1:0] BRA = 4'b0011;
  localparam logic [OPW-1:0] XOR = 4'b0100;
  localparam logic [OPW-1:0] ADD = 4'b0101;
  localparam logic [OPW-1:0] ROT = 4'b0110;
  localparam logic [OPW-1:0] SHF = 4'b0111;
  localparam logic [OPW-1:0] HLT = 4'b1000;
  localparam logic [OPW-1:0] CMP = 4'b1001;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    HALTED = 2'd2
  } issue_state_e;

  typedef struct packed {
    logic [OPW-1:0]  opcode;
    logic [DATW-1:0] dst;
    logic [DATW-1:0] src;
    logic            imm;
  } instr_t;

endpackage

// File: rtl/issue_fifo.sv
// Generic synchronous FIFO, registered pointers, combinational read of the head.
// Push into a full FIFO or pop from an empty one is ignored.
module issue_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rp];

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= wdata;
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop)  rp <= rp + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_issue.sv
// Issue buffer to proc: one outstanding instruction, first issue two edges after accept; HLT at head stops issue.
// in_ready drops when full or halted. Defining INSTR_ISSUE_STATS_EN adds saturating issued_cnt/stall_cnt outputs.
module instr_issue #(
  parameter int             BUSW  = 32,
  parameter int             OPW   = 4,
  parameter int             DEPTH = 4,
  parameter logic [OPW-1:0] HLT   = 4'b1000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OPW-1:0]  in_opcode,
  input  logic [BUSW-1:0] in_dst,
  input  logic [BUSW-1:0] in_src,
  input  logic            in_imm,
  output logic [OPW-1:0]  OpCode,
  output logic [BUSW-1:0] DstOp,
  output logic [BUSW-1:0] SrcOp,
  output logic            srcIsImm,
  output logic            issue_valid,
  input  logic            resvalid,
  output logic            halted
`ifdef INSTR_ISSUE_STATS_EN
  ,
  output logic [15:0]     issued_cnt,
  output logic [15:0]     stall_cnt
`endif
);

  import proc_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [OPW-1:0]  opcode;
    logic [BUSW-1:0] dst;
    logic [BUSW-1:0] src;
    logic            imm;
  } entry_t;

  issue_state_e         state;
  entry_t               wr_ent;
  entry_t               head;
  logic [$bits(entry_t)-1:0] head_raw;
  logic [CW-1:0]        count;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;
  logic                 issue_now;

  assign wr_ent.opcode = in_opcode;
  assign wr_ent.dst    = in_dst;
  assign wr_ent.src    = in_src;
  assign wr_ent.imm    = in_imm;
  assign head          = entry_t'(head_raw);

  // A pop on the same edge never frees room for a push: readiness looks only at the current count.
  assign in_ready  = (count < CW'(DEPTH)) && (state != HALTED);
  assign push      = in_valid && in_ready;
  assign pop       = (state == IDLE) && !empty;
  assign issue_now = pop && (head.opcode != HLT);

  issue_fifo #(
    .W     ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (wr_ent),
    .pop   (pop),
    .rdata (head_raw),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  full_matches_count : assert property (@(posedge clk) disable iff (!rst_n)
    full == (count == CW'(DEPTH)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      OpCode      <= '0;
      DstOp       <= '0;
      SrcOp       <= '0;
      srcIsImm    <= 1'b0;
      issue_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      issue_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (issue_now) begin
            OpCode      <= head.opcode;
            DstOp       <= head.dst;
            SrcOp       <= head.src;
            srcIsImm    <= head.imm;
            issue_valid <= 1'b1;
            state       <= WAIT;
          end else if (pop) begin
            // HLT is consumed silently; operand outputs keep the last issue.
            halted <= 1'b1;
            state  <= HALTED;
          end
        end
        WAIT:    if (resvalid) state <= IDLE;
        HALTED:  state <= HALTED;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef INSTR_ISSUE_STATS_EN
  logic [1:0]  stall_inc;
  logic [16:0] stall_sum;

  assign stall_inc = 2'((state == WAIT)) +
                     2'((in_valid && !in_ready && state != HALTED));
  assign stall_sum = {1'b0, stall_cnt} + 17'(stall_inc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      if (issue_now && issued_cnt != 16'hFFFF) issued_cnt <= issued_cnt + 16'd1;
      stall_cnt <= stall_sum[16] ? 16'hFFFF : stall_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_instr_issue.sv
// Directed bench for instr_issue with a queue-level reference model checked every cycle.
module tb_instr_issue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_opcode = '0;
  logic [31:0] in_dst = '0;
  logic [31:0] in_src = '0;
  logic        in_imm = 1'b0;
  logic [3:0]  OpCode;
  logic [31:0] DstOp;
  logic [31:0] SrcOp;
  logic        srcIsImm;
  logic        issue_valid;
  logic        resvalid = 1'b0;
  logic        halted;
`ifdef INSTR_ISSUE_STATS_EN
  logic [15:0] issued_cnt;
  logic [15:0] stall_cnt;
`endif

  instr_issue #(.BUSW(32), .OPW(4), .DEPTH(DEPTH), .HLT(4'b1000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_opcode   (in_opcode),
    .in_dst      (in_dst),
    .in_src      (in_src),
    .in_imm      (in_imm),
    .OpCode      (OpCode),
    .DstOp       (DstOp),
    .SrcOp       (SrcOp),
    .srcIsImm    (srcIsImm),
    .issue_valid (issue_valid),
    .resvalid    (resvalid),
    .halted      (halted)
`ifdef INSTR_ISSUE_STATS_EN
    ,
    .issued_cnt  (issued_cnt),
    .stall_cnt   (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model: instruction queue + busy/halt flags
  typedef struct {
    logic [3:0]  op;
    logic [31:0] dst;
    logic [31:0] src;
    logic        imm;
  } ent_t;

  ent_t mq[$];
  ent_t m_last;
  bit   m_busy, m_halt, m_pulse;
  ent_t dut_log[$];

  function automatic bit m_ready();
    return (mq.size() < DEPTH) && !m_halt;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_busy  = 0;
      m_halt  = 0;
      m_pulse = 0;
      m_last  = '{op: 4'h0, dst: 32'h0, src: 32'h0, imm: 1'b0};
    end else begin
      int   sz;
      bit   acc;
      ent_t e;
      sz  = mq.size();
      acc = in_valid && (sz < DEPTH) && !m_halt;
      m_pulse = 0;
      if (m_halt) begin
        m_halt = 1;
      end else if (m_busy) begin
        if (resvalid) m_busy = 0;
      end else if (sz > 0) begin
        e = mq.pop_front();
        if (e.op == 4'b1000) m_halt = 1;
        else begin
          m_last  = e;
          m_pulse = 1;
          m_busy  = 1;
        end
      end
      if (acc) mq.push_back('{op: in_opcode, dst: in_dst, src: in_src, imm: in_imm});
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("issue_valid", issue_valid, m_pulse);
      check("in_ready", in_ready, m_ready());
      check("halted", halted, m_halt);
      check("operands", {OpCode, DstOp, SrcOp, srcIsImm},
            {m_last.op, m_last.dst, m_last.src, m_last.imm});
      if (issue_valid) dut_log.push_back('{op: OpCode, dst: DstOp, src: SrcOp, imm: srcIsImm});
    end
  end

  // ---------------- stimulus helpers
  task automatic drive(input logic [3:0] op, input logic [31:0] d, input logic [31:0] s, input logic im);
    in_valid  = 1'b1;
    in_opcode = op;
    in_dst    = d;
    in_src    = s;
    in_imm    = im;
  endtask

  task automatic do_reset;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    resvalid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [3:0] full_op(input int i);
    case (i)
      0: return 4'b0001;
      1: return 4'b0010;
      2: return 4'b0011;
      3: return 4'b0110;
      4: return 4'b0111;
      default: return 4'b1001;
    endcase
  endfunction

  function automatic logic [3:0] wrap_op(input int i);
    case (i)
      0: return 4'b0000;
      1: return 4'b0001;
      2: return 4'b0010;
      3: return 4'b0011;
      4: return 4'b0100;
      5: return 4'b0101;
      6: return 4'b0110;
      7: return 4'b0111;
      8: return 4'b1001;
      default: return 4'b0101;
    endcase
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int  idx;
    bit  rdy;
    int  since;

    // Reset state
    rst_n = 1'b0;
    #2;
    check("reset_in_ready_async", in_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("reset_outputs", {OpCode, DstOp, SrcOp, srcIsImm, issue_valid, halted}, 80'h0);
    check("reset_in_ready", in_ready, 1'b1);
    tick;

    // Single issue, hold, then next queued instruction after resvalid
    drive(4'b0101, 32'h5, 32'h3, 1'b0);
    tick;
    check("single_no_issue_yet", issue_valid, 1'b0);
    drive(4'b0100, 32'h7, 32'h9, 1'b1);
    tick;
    in_valid = 1'b0;
    check("single_issue_pulse", issue_valid, 1'b1);
    check("single_issue_fields", {OpCode, DstOp, SrcOp, srcIsImm}, {4'b0101, 32'h5, 32'h3, 1'b0});
    repeat (4) tick;
    check("hold_no_issue", issue_valid, 1'b0);
    check("hold_opcode", OpCode, 4'b0101);
    resvalid = 1'b1;
    tick;
    resvalid = 1'b0;
    check("after_res_idle", issue_valid, 1'b0);
    tick;
    check("second_issue", {issue_valid, OpCode, DstOp, SrcOp, srcIsImm},
          {1'b1, 4'b0100, 32'h7, 32'h9, 1'b1});
    resvalid = 1'b1;
    tick;
    resvalid = 1'b0;
    repeat (2) tick;

    // Full FIFO with proc never answering
    do_reset;
    idx = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (idx < 6) drive(full_op(idx), 32'h10 + 32'(idx), 32'(idx * 2), 1'b0);
      else in_valid = 1'b0;
      rdy = in_ready;
      tick;
      if (in_valid && rdy) idx++;
    end
    in_valid = 1'b0;
    check("full_accepted", 32'(idx), 32'd5);
    check("full_in_ready", in_ready, 1'b0);
    check("full_count", dut.u_fifo.count, 3'd4);
    check("full_first_issued", OpCode, 4'b0001);

    // Asynchronous reset mid-WAIT, with a stale result pending
    rst_n    = 1'b0;
    resvalid = 1'b1;
    #1;
    check("midwait_count", dut.u_fifo.count, 3'd0);
    check("midwait_issue_valid", issue_valid, 1'b0);
    check("midwait_in_ready", in_ready, 1'b1);
    check("midwait_opcode", OpCode, 4'b0000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick;
    resvalid = 1'b0;
    tick;
    check("stale_result_ignored", {issue_valid, halted}, 2'b00);

    // Halt: XOR issues, HLT stops everything, ADD is retained
    drive(4'b0100, 32'h1, 32'h2, 1'b0);
    tick;
    drive(4'b1000, 32'h0, 32'h0, 1'b0);
    tick;
    drive(4'b0101, 32'h3, 32'h4, 1'b1);
    tick;
    in_valid = 1'b0;
    tick;
    resvalid = 1'b1;
    tick;
    resvalid = 1'b0;
    tick;
    check("halt_flags", {halted, in_ready, issue_valid}, 3'b100);
    check("halt_opcode_kept", {OpCode, DstOp, SrcOp}, {4'b0100, 32'h1, 32'h2});
    drive(4'b0001, 32'hAA, 32'hBB, 1'b0);
    resvalid = 1'b1;
    repeat (3) tick;
    in_valid = 1'b0;
    resvalid = 1'b0;
    check("halt_absorbing", {halted, in_ready, issue_valid}, 3'b100);
    check("halt_retained", dut.u_fifo.count, 3'd1);

    // Wrap: continuous push/pop of 10 instructions, proc answers next cycle
    do_reset;
    dut_log.delete();
    idx = 0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      if (idx < 10) drive(wrap_op(idx), 32'h100 + 32'(idx), 32'hA0 + 32'(idx * idx), idx[0]);
      else in_valid = 1'b0;
      resvalid = issue_valid;
      rdy = in_ready;
      tick;
      if (in_valid && rdy) idx++;
      if (idx == 10 && dut_log.size() == 10) break;
    end
    in_valid = 1'b0;
    resvalid = 1'b0;
    check("wrap_count", 32'(dut_log.size()), 32'd10);
    for (int i = 0; i < 10; i++) begin
      if (i < dut_log.size())
        check("wrap_order", {dut_log[i].op, dut_log[i].dst, dut_log[i].src, dut_log[i].imm},
              {wrap_op(i), 32'h100 + 32'(i), 32'hA0 + 32'(i * i), i[0]});
    end
    tick;

`ifdef INSTR_ISSUE_STATS_EN
    // Stats: three issues, each held in WAIT for four cycles
    do_reset;
    check("stats_reset", {issued_cnt, stall_cnt}, 32'h0);
    idx   = 0;
    since = 100;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (issue_valid) since = 0;
      else since++;
      resvalid = (since == 3);
      if (idx < 3) drive(4'b0101, 32'(idx), 32'(idx + 1), 1'b0);
      else in_valid = 1'b0;
      rdy = in_ready;
      tick;
      if (in_valid && rdy) idx++;
    end
    in_valid = 1'b0;
    resvalid = 1'b0;
    check("stats_issued", issued_cnt, 16'd3);
    check("stats_stall", stall_cnt, 16'd12);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
